// File: rtl/cmd_frame_dispatch.sv
// Command frame receiver and payload dispatcher.
// Parses HDR0 HDR1 CMD LEN <payload> CHK from an unthrottled byte stream,
// buffers the payload and verifies the additive checksum. Good frames are
// replayed on a ready/valid payload stream framed by cmd_start/cmd_done.
// Protocol faults are reported as single-cycle error pulses.
`timescale 1ns / 1ps
module cmd_frame_dispatch #(
  parameter int unsigned MAX_PAYLOAD    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  parameter logic [7:0]  HDR0           = 8'hAA,
  parameter logic [7:0]  HDR1           = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] usb_data_in,
  input  logic       usb_data_valid_in,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_len,
  output logic       cmd_start,
  output logic       cmd_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_checksum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MaxLen    = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCmd,
    StLen,
    StPayload,
    StChk,
    StDispatch
  } state_e;

  state_e        r_state;
  logic [7:0]    r_cmd;
  logic [7:0]    r_len;
  logic [7:0]    r_sum;
  // Shared index: write pointer while receiving, read pointer while dispatching.
  logic [7:0]    r_idx;
  logic [TW-1:0] r_timer;

  logic [7:0]    r_cmd_code;
  logic [7:0]    r_cmd_len;
  logic          r_cmd_start;
  logic          r_cmd_done;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_err_checksum;
  logic          r_err_len;
  logic          r_err_timeout;
  logic          r_err_overrun;
  logic          r_busy;

  logic [7:0]    r_buf [MAX_PAYLOAD];

  logic          w_buf_we;
  logic [AW-1:0] w_buf_addr;
  logic [7:0]    w_rd_data;

  // Payload buffer port decode: written only while collecting payload bytes.
  always_comb begin
    w_buf_we   = (r_state == StPayload) && usb_data_valid_in;
    w_buf_addr = r_idx[AW-1:0];
    w_rd_data  = r_buf[w_buf_addr];
  end

  // Payload storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[w_buf_addr] <= usb_data_in;
    end
  end

  // Frame parser, dispatcher and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cmd          <= '0;
      r_len          <= '0;
      r_sum          <= '0;
      r_idx          <= '0;
      r_timer        <= '0;
      r_cmd_code     <= '0;
      r_cmd_len      <= '0;
      r_cmd_start    <= 1'b0;
      r_cmd_done     <= 1'b0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_len      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Pulses default low; branches below raise them for one cycle.
      r_cmd_start    <= 1'b0;
      r_cmd_done     <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_len      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;

      case (r_state)
        StIdle: begin
          r_timer <= '0;
          if (usb_data_valid_in && (usb_data_in == HDR0)) begin
            r_state <= StSync;
            r_busy  <= 1'b1;
          end
        end

        StDispatch: begin
          // No backpressure upstream, so a byte here is lost and flagged.
          if (usb_data_valid_in) begin
            r_err_overrun <= 1'b1;
          end
          if (r_cmd_start) begin
            if (r_cmd_len == 8'd0) begin
              r_cmd_done <= 1'b1;
              r_state    <= StIdle;
              r_busy     <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rd_data;
              r_idx       <= r_idx + 8'd1;
            end
          end else if (r_out_valid && out_ready) begin
            if (r_idx == r_cmd_len) begin
              r_out_valid <= 1'b0;
              r_cmd_done  <= 1'b1;
              r_state     <= StIdle;
              r_busy      <= 1'b0;
            end else begin
              r_out_data <= w_rd_data;
              r_idx      <= r_idx + 8'd1;
            end
          end
        end

        default: begin
          // Receiving states: a byte restarts the inter-byte timer.
          if (usb_data_valid_in) begin
            r_timer <= '0;
            case (r_state)
              StSync: begin
                if (usb_data_in == HDR1) begin
                  r_state <= StCmd;
                  r_sum   <= '0;
                end else if (usb_data_in != HDR0) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                end
              end

              StCmd: begin
                r_cmd   <= usb_data_in;
                r_sum   <= r_sum + usb_data_in;
                r_state <= StLen;
              end

              StLen: begin
                r_len <= usb_data_in;
                r_sum <= r_sum + usb_data_in;
                r_idx <= '0;
                if (usb_data_in > MaxLen) begin
                  r_err_len <= 1'b1;
                  r_state   <= StIdle;
                  r_busy    <= 1'b0;
                end else if (usb_data_in == 8'd0) begin
                  r_state <= StChk;
                end else begin
                  r_state <= StPayload;
                end
              end

              StPayload: begin
                r_sum <= r_sum + usb_data_in;
                if (r_idx == (r_len - 8'd1)) begin
                  r_state <= StChk;
                end else begin
                  r_idx <= r_idx + 8'd1;
                end
              end

              StChk: begin
                if (usb_data_in == r_sum) begin
                  r_state     <= StDispatch;
                  r_cmd_start <= 1'b1;
                  r_cmd_code  <= r_cmd;
                  r_cmd_len   <= r_len;
                  r_idx       <= '0;
                end else begin
                  r_err_checksum <= 1'b1;
                  r_state        <= StIdle;
                  r_busy         <= 1'b0;
                end
              end

              default: begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end
            endcase
          end else if (r_timer == TimerLast) begin
            r_err_timeout <= 1'b1;
            r_timer       <= '0;
            r_state       <= StIdle;
            r_busy        <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
      endcase
    end
  end

  assign cmd_code     = r_cmd_code;
  assign cmd_len      = r_cmd_len;
  assign cmd_start    = r_cmd_start;
  assign cmd_done     = r_cmd_done;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign err_checksum = r_err_checksum;
  assign err_len      = r_err_len;
  assign err_timeout  = r_err_timeout;
  assign err_overrun  = r_err_overrun;
  assign busy         = r_busy;

endmodule

// File: tb/tb_cmd_frame_dispatch.sv
// Scoreboard bench for cmd_frame_dispatch: expected commands, payload bytes
// and pulse events are queued as frames are driven and retired by a monitor.
`timescale 1ns / 1ps
module tb_cmd_frame_dispatch;

  localparam int unsigned MaxPayload = 64;
  localparam int unsigned Timeout    = 300;

  localparam int EvChk  = 1;
  localparam int EvLen  = 2;
  localparam int EvTo   = 3;
  localparam int EvOvr  = 4;
  localparam int EvDone = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] usb_data_in = 8'h00;
  logic       usb_data_valid_in = 1'b0;
  logic [7:0] cmd_code;
  logic [7:0] cmd_len;
  logic       cmd_start;
  logic       cmd_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       err_checksum;
  logic       err_len;
  logic       err_timeout;
  logic       err_overrun;
  logic       busy;

  cmd_frame_dispatch #(
    .MAX_PAYLOAD   (MaxPayload),
    .TIMEOUT_CYCLES(Timeout),
    .HDR0          (8'hAA),
    .HDR1          (8'h55)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .usb_data_in      (usb_data_in),
    .usb_data_valid_in(usb_data_valid_in),
    .cmd_code         (cmd_code),
    .cmd_len          (cmd_len),
    .cmd_start        (cmd_start),
    .cmd_done         (cmd_done),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .err_checksum     (err_checksum),
    .err_len          (err_len),
    .err_timeout      (err_timeout),
    .err_overrun      (err_overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_cmd_q  [$];
  logic [7:0]  exp_data_q [$];
  int          exp_evt_q  [$];
  logic [7:0]  tx_q       [$];
  logic [7:0]  pl         [256];

  bit          strict      = 1'b0;
  bit          rand_ready  = 1'b0;
  int unsigned t_last_byte = 0;
  int unsigned t_start     = 0;
  int unsigned n_xfer      = 0;
  int unsigned n_start     = 0;
  logic [7:0]  hold_code   = 8'h00;
  logic [7:0]  hold_len    = 8'h00;
  bit          prev_stall  = 1'b0;
  logic [7:0]  prev_data   = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_evt(input int code, input string tag);
    if (exp_evt_q.size() == 0) check({tag, "_pending_evts"}, exp_evt_q.size(), 1);
    else check(tag, code, exp_evt_q.pop_front());
  endtask

  // Monitor: retire scoreboard entries as the DUT produces them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;

      if (cmd_start) begin
        if (exp_cmd_q.size() == 0) check("start_pending_cmds", exp_cmd_q.size(), 1);
        else check("cmd_code_len", {cmd_code, cmd_len}, exp_cmd_q.pop_front());
        check("busy_at_start", busy, 1);
        t_start   <= cyc;
        n_xfer    <= 0;
        hold_code <= cmd_code;
        hold_len  <= cmd_len;
        n_start   <= n_start + 1;
      end

      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) check("data_pending_bytes", exp_data_q.size(), 1);
        else check("out_data", out_data, exp_data_q.pop_front());
        if (strict) check("xfer_latency", cyc - t_start, 1 + n_xfer);
        n_xfer <= n_xfer + 1;
      end

      if (cmd_done) begin
        pop_evt(EvDone, "cmd_done");
        check("done_code_len_held", {cmd_code, cmd_len}, {hold_code, hold_len});
        check("done_busy", busy, 0);
        if (strict) check("done_latency", cyc - t_start, 1 + hold_len);
      end
      if (err_checksum) pop_evt(EvChk, "err_checksum");
      if (err_len) pop_evt(EvLen, "err_len");
      if (err_timeout) begin
        pop_evt(EvTo, "err_timeout");
        check("timeout_latency",
              32'((cyc - t_last_byte >= Timeout) && (cyc - t_last_byte <= Timeout + 1)), 1);
      end
      if (err_overrun) pop_evt(EvOvr, "err_overrun");
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    usb_data_in       = b;
    usb_data_valid_in = 1'b1;
    @(posedge clk);
    #1;
    usb_data_valid_in = 1'b0;
    t_last_byte       = cyc;
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] chk_xor);
    logic [7:0] sum;
    sum  = cmd + 8'(len);
    tx_q = '{8'hAA, 8'h55, cmd, 8'(len)};
    for (int i = 0; i < len; i++) begin
      tx_q.push_back(pl[i]);
      sum = sum + pl[i];
    end
    tx_q.push_back(sum ^ chk_xor);
    send_q();
  endtask

  task automatic expect_dispatch(input logic [7:0] cmd, input int len);
    exp_cmd_q.push_back({cmd, 8'(len)});
    for (int i = 0; i < len; i++) exp_data_q.push_back(pl[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_cmd_q.size() + exp_data_q.size() + exp_evt_q.size()) != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(3);
    check({tag, "_drained"}, exp_cmd_q.size() + exp_data_q.size() + exp_evt_q.size(), 0);
  endtask

  task automatic wait_start(input string tag);
    int unsigned s0;
    int n;
    s0 = n_start;
    n  = 0;
    while (n_start == s0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(n_start != s0), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_len", cmd_len, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cmd_start", cmd_start, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_errs", {err_checksum, err_len, err_timeout, err_overrun}, 0);
    rst_n = 1'b1;
    idle(2);

    // Three-byte frame, continuous ready.
    strict = 1'b1;
    exp_cmd_q.push_back(16'h1003);
    exp_data_q.push_back(8'h01);
    exp_data_q.push_back(8'h02);
    exp_data_q.push_back(8'h03);
    exp_evt_q.push_back(EvDone);
    tx_q = '{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_q();
    drain("frame3");

    // Zero-length frame.
    exp_cmd_q.push_back(16'h2000);
    exp_evt_q.push_back(EvDone);
    tx_q = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h20};
    send_q();
    drain("frame0");

    // Bad checksum (0x16 expected).
    exp_evt_q.push_back(EvChk);
    tx_q = '{8'hAA, 8'h55, 8'h10, 8'h01, 8'h05, 8'h00};
    send_q();
    drain("badchk");
    check("busy_after_badchk", busy, 0);

    // Oversized length after doubled header byte.
    exp_evt_q.push_back(EvLen);
    tx_q = '{8'hAA, 8'hAA, 8'h55, 8'h10, 8'h41};
    send_q();
    drain("badlen");
    check("busy_after_badlen", busy, 0);

    // Broken sync must fall back to idle, so nothing dispatches here.
    tx_q = '{8'hAA, 8'h12, 8'h55, 8'h10, 8'h00, 8'h10};
    send_q();
    drain("badsync");
    check("busy_after_badsync", busy, 0);

    // Inter-byte timeout, then recovery.
    exp_evt_q.push_back(EvTo);
    tx_q = '{8'hAA, 8'h55, 8'h10};
    send_q();
    check("busy_mid_frame", busy, 1);
    drain("timeout");
    pl[0] = 8'h7F;
    pl[1] = 8'h80;
    expect_dispatch(8'h30, 2);
    exp_evt_q.push_back(EvDone);
    send_frame(8'h30, 2, 8'h00);
    drain("after_timeout");

    // Stalled four-byte dispatch with an injected byte.
    strict = 1'b0;
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    pl[2] = 8'h33;
    pl[3] = 8'h44;
    expect_dispatch(8'h40, 4);
    exp_evt_q.push_back(EvOvr);
    exp_evt_q.push_back(EvDone);
    send_frame(8'h40, 4, 8'h00);
    wait_start("stall");
    for (int i = 0; i < 16; i++) begin
      out_ready         = pat[i % 4];
      usb_data_in       = 8'hC3;
      usb_data_valid_in = (i == 1);
      @(posedge clk);
      #1;
    end
    usb_data_valid_in = 1'b0;
    out_ready         = 1'b1;
    drain("stall");

    // Random payloads with random backpressure, including the MAX_PAYLOAD boundary.
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int len;
      logic [7:0] cmd;
      len = (f == 0) ? MaxPayload : ((f == 3) ? 1 : int'($urandom_range(1, MaxPayload)));
      cmd = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
      expect_dispatch(cmd, len);
      exp_evt_q.push_back(EvDone);
      send_frame(cmd, len, 8'h00);
      drain("random");
    end
    rand_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;

    // Reset in the middle of a dispatch: no cmd_done may follow.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    expect_dispatch(8'h50, 8);
    send_frame(8'h50, 8, 8'h00);
    wait_start("midrst");
    idle(2);
    rst_n = 1'b0;
    #1;
    exp_data_q.delete();
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cmd_code", cmd_code, 0);
    idle(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drain("midrst");

    // Normal operation after the mid-dispatch reset.
    strict = 1'b1;
    pl[0]  = 8'hAA;
    expect_dispatch(8'h60, 1);
    exp_evt_q.push_back(EvDone);
    send_frame(8'h60, 1, 8'h00);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_dispatch.md
CMD_FRAME_DISPATCH -- requirements
Module: cmd_frame_dispatch

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, meaning the largest accepted payload length in bytes (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 60000, meaning the inter-byte timeout in clk cycles (1 ms at 60 MHz PHY clock).
REQ-003 SHALL have parameters HDR0 = 8'hAA and HDR1 = 8'h55, meaning the frame sync bytes.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock, the USB PHY clock domain.
REQ-005 SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have the port usb_data_in, input, 8 bits: received byte; usb_data_valid_in, input, 1 bit: byte strobe (no backpressure).
REQ-007 SHALL have the ports cmd_code and cmd_len, output, 8 bits each: the command and length of the frame being dispatched.
REQ-008 SHALL have the ports cmd_start and cmd_done, output, 1 bit each: single-cycle dispatch start and end pulses.
REQ-009 SHALL have the ports out_data, output, 8 bits; out_valid, output, 1 bit; out_ready, input, 1 bit: the payload stream.
REQ-010 SHALL have the ports err_checksum, err_len, err_timeout and err_overrun, output, 1 bit each: single-cycle error pulses.
REQ-011 SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL use the frame format HDR0, HDR1, CMD, LEN, LEN payload bytes, CHK, where CHK = (CMD + LEN + sum of payload bytes) mod 256.
REQ-013 SHALL have the FSM states IDLE, SYNC, CMD, LEN, PAYLOAD, CHK, DISPATCH; each accepted byte advances at most one state.
REQ-014 SHALL, in IDLE, move to SYNC on byte == HDR0; other bytes are ignored.
REQ-015 SHALL, in SYNC, move to CMD on byte == HDR1, stay in SYNC on byte == HDR0, and otherwise go to IDLE.
REQ-016 SHALL, in LEN, with LEN > MAX_PAYLOAD, pulse err_len and go to IDLE; with LEN == 0 go to CHK; otherwise go to PAYLOAD.
REQ-017 SHALL, in PAYLOAD, write the bytes to an internal buffer (MAX_PAYLOAD x 8) at address 0..LEN-1, then go to CHK.
REQ-018 SHALL, in CHK, go to DISPATCH when the checksum matches, and otherwise pulse err_checksum and go to IDLE with no dispatch.
REQ-019 SHALL pulse cmd_start in the first DISPATCH cycle, with cmd_code and cmd_len valid at that cycle and held stable until cmd_done.
REQ-020 SHALL assert out_valid from the cycle after cmd_start, present payload bytes in order, and transfer a byte only on out_valid && out_ready.
REQ-021 SHALL hold out_data and out_valid stable while out_ready is low.
REQ-022 SHALL pulse cmd_done the cycle after the last transfer (or the cycle after cmd_start when LEN == 0), then return to IDLE.
REQ-023 SHALL, on a usb_data_valid_in byte during DISPATCH, discard the byte and pulse err_overrun, leaving the dispatch unaffected.
REQ-024 SHALL run a timeout counter in SYNC/CMD/LEN/PAYLOAD/CHK that clears on each received byte.
REQ-025 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1, pulse err_timeout and go to IDLE; DISPATCH has no timeout.
REQ-026 SHALL compute the running checksum in 8-bit modulo arithmetic, cleared on entry to CMD.
REQ-027 SHALL make all outputs registered.

Reset
REQ-028 SHALL, while rst_n is low, force state = IDLE, all pulses and out_valid = 0, cmd_code = cmd_len = out_data = 0, busy = 0, and the counters = 0.
REQ-029 SHALL, on reset mid-frame or mid-dispatch, abandon the frame with no cmd_done; the buffer contents are don't-care.

Verification
REQ-030 SHALL cover: frame AA 55 10 03 01 02 03 19 with out_ready = 1 -> cmd_start with code 8'h10 and len 3, out_data 01, 02, 03 on consecutive cycles, then cmd_done.
REQ-031 SHALL cover: AA 55 20 00 20 -> cmd_start with len 0, cmd_done the next cycle, no out_valid.
REQ-032 SHALL cover: AA 55 10 01 05 00 (bad CHK, expected 8'h16) -> err_checksum pulse, no cmd_start, busy = 0.
REQ-033 SHALL cover: AA AA 55 10 41 (LEN 65 > 64) -> err_len pulse; the doubled HDR0 is tolerated.
REQ-034 SHALL cover: AA 55 10, then idle for TIMEOUT_CYCLES -> err_timeout, and a following valid frame dispatches normally.
REQ-035 SHALL cover: out_ready toggled 1-0-0-1 during a 4-byte dispatch with a byte injected -> data held stable while stalled, err_overrun pulse, all 4 bytes delivered.
